// File: rtl/triple_operand_accumulator_if.sv
// Beat and result bundle between the triple-operand adder stage, this
// accumulator and its consumer.
interface triple_operand_accumulator_if #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in1;
    logic [3:0]       in2;
    logic [3:0]       in3;
    logic             cin;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;
    logic [CNT_W-1:0] out_beats;

    modport master (
        output in_valid, in1, in2, in3, cin, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_beats
    );

    modport slave (
        input  in_valid, in1, in2, in3, cin, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_beats
    );
endinterface

// File: rtl/triple_operand_accumulator.sv
// Streaming accumulator for 3-operand beats. Each beat is reduced to a
// 6-bit triple sum {cout_2, cout_1, sum[3:0]} and folded into a wide
// running total; the total, a sticky overflow and the beat count are
// presented once per packet.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_ACC   | accepting beats, in_ready=1; last-beat handshake -> ST_FLUSH
// ST_FLUSH | final stage-1 beat folds into acc/ovf/cnt; -> ST_DONE
// ST_DONE  | result on output port; out_ready clears totals -> ST_ACC
module triple_operand_accumulator #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    triple_operand_accumulator_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             s1_val_q;
    logic [5:0]       s1_t_q;
    logic             s1_last_q;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;

    logic             hs;
    logic             clear;
    logic [5:0]       t;
    logic [ACC_W:0]   acc_sum;

    // The FSM already tracks the packet end; s1_last is kept so the stage-1
    // register carries the full beat for debug visibility.
    logic             unused_s1_last;
    assign unused_s1_last = s1_last_q;

    // in_ready is held low while reset is asserted, independent of state.
    assign bus.in_ready = (state_q == ST_ACC) && !rst;
    assign hs           = bus.in_valid && bus.in_ready;
    assign clear        = (state_q == ST_DONE) && bus.out_ready;

    // Triple sum: max 15+15+15+1 = 46, fits in 6 bits.
    assign t = {2'b00, bus.in1} + {2'b00, bus.in2} + {2'b00, bus.in3} + {5'd0, bus.cin};

    // One extra bit captures the carry out of the accumulator MSB.
    assign acc_sum = {1'b0, acc_q} + {{(ACC_W-5){1'b0}}, s1_t_q};

    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_sum   = acc_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_beats = cnt_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_ACC;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:   if (hs && bus.in_last) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  if (bus.out_ready) state_d = ST_ACC;
            default:  state_d = ST_ACC;
        endcase
    end

    // Stage 1: capture the reduced beat on each handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_val_q  <= 1'b0;
            s1_t_q    <= 6'd0;
            s1_last_q <= 1'b0;
        end else begin
            s1_val_q <= hs;
            if (hs) begin
                s1_t_q    <= t;
                s1_last_q <= bus.in_last;
            end
        end
    end

    // Stage 2: running total, sticky overflow and saturating beat count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (s1_val_q) begin
            acc_q <= acc_sum[ACC_W-1:0];
            ovf_q <= ovf_q | acc_sum[ACC_W];
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_triple_operand_accumulator.sv
// Bench for triple_operand_accumulator: a 16-bit and an 8-bit instance
// share one stimulus stream so wide totals and the overflow path are both
// checked against plain-arithmetic expectations.
module tb_triple_operand_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    triple_operand_accumulator_if #(.ACC_W(16), .CNT_W(8)) bus ();
    triple_operand_accumulator_if #(.ACC_W(8),  .CNT_W(8)) bus8 ();

    assign bus8.in_valid  = bus.in_valid;
    assign bus8.in1       = bus.in1;
    assign bus8.in2       = bus.in2;
    assign bus8.in3       = bus.in3;
    assign bus8.cin       = bus.cin;
    assign bus8.in_last   = bus.in_last;
    assign bus8.out_ready = bus.out_ready;

    triple_operand_accumulator #(.ACC_W(16), .CNT_W(8)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    triple_operand_accumulator #(.ACC_W(8), .CNT_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int n;
        int a, b, c, ci;
        int s16, o16, s8, o8, beats;
        int stall;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int a, input int b, input int c, input int ci, input bit last);
        bit rdy;
        int n;
        logic [3:0] a4, b4, c4;
        a4 = a[3:0]; b4 = b[3:0]; c4 = c[3:0];
        bus.in_valid = 1'b1;
        bus.in1 = a4; bus.in2 = b4; bus.in3 = c4;
        bus.cin = ci[0];
        bus.in_last = last;
        n = 0;
        do begin
            rdy = bus.in_ready;
            tick();
            n++;
        end while (!rdy && n < 100);
        if (!rdy) check("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Returns edges from the last-beat handshake to out_valid high.
    task automatic wait_result(output int lat);
        int n;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        if (!bus.out_valid) check("result_timeout", 0, 1);
        lat = n + 1;
    endtask

    task automatic finish_result(input string name, input int s16, input int o16, input int s8,
                                 input int o8, input int beats, input int stall);
        check({name, "_sum16"}, bus.out_sum, s16);
        check({name, "_ovf16"}, bus.out_ovf, o16);
        check({name, "_sum8"},  bus8.out_sum, s8);
        check({name, "_ovf8"},  bus8.out_ovf, o8);
        check({name, "_beats"}, bus.out_beats, beats);
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'($urandom);
            bus.in_last  = 1'b1;
            bus.in1 = 4'($urandom); bus.in2 = 4'($urandom); bus.in3 = 4'($urandom);
            bus.cin = 1'($urandom);
            tick();
            check({name, "_hold_valid"}, bus.out_valid, 1);
            check({name, "_hold_ready"}, bus.in_ready, 0);
            check({name, "_hold_sum"},   bus.out_sum, s16);
            check({name, "_hold_sum8"},  bus8.out_sum, s8);
            check({name, "_hold_ovf8"},  bus8.out_ovf, o8);
            check({name, "_hold_beats"}, bus.out_beats, beats);
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({name, "_clr_valid"}, bus.out_valid, 0);
        check({name, "_clr_ready"}, bus.in_ready, 1);
        check({name, "_clr_sum"},   bus.out_sum, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int len, acc, a, b, c, ci, bmax;

        vecs[0] = '{4, 15, 15, 15, 1, 184, 0, 184, 0, 4, 0};
        vecs[1] = '{1,  3,  5,  9, 0,  17, 0,  17, 0, 1, 0};
        vecs[2] = '{6, 15, 15, 15, 1, 276, 0,  20, 1, 6, 0};
        vecs[3] = '{1,  1,  0,  0, 0,   1, 0,   1, 0, 1, 5};
        vecs[4] = '{3,  0,  0,  0, 0,   0, 0,   0, 0, 3, 0};
        vecs[5] = '{2,  4,  3,  2, 1,  20, 0,  20, 0, 2, 2};

        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        bus.in1 = 4'd0; bus.in2 = 4'd0; bus.in3 = 4'd0; bus.cin = 1'b0;

        // Reset state.
        tick();
        check("rst_in_ready",  bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sum",   bus.out_sum, 0);
        check("rst_out_ovf",   bus.out_ovf, 0);
        check("rst_out_beats", bus.out_beats, 0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);

        // Table-driven packets of identical beats.
        foreach (vecs[k]) begin
            for (int i = 0; i < vecs[k].n; i++)
                send_beat(vecs[k].a, vecs[k].b, vecs[k].c, vecs[k].ci, i == vecs[k].n - 1);
            check($sformatf("vec%0d_flush_valid", k), bus.out_valid, 0);
            wait_result(lat);
            check($sformatf("vec%0d_latency", k), lat, 2);
            finish_result($sformatf("vec%0d", k), vecs[k].s16, vecs[k].o16, vecs[k].s8,
                          vecs[k].o8, vecs[k].beats, vecs[k].stall);
        end

        // Reset mid-packet after 3 of 5 beats of t=10.
        for (int i = 0; i < 3; i++) send_beat(4, 3, 2, 1, 1'b0);
        tick();
        check("pre_rst_sum", bus.out_sum, 30);
        rst = 1'b1;
        #1;
        check("midrst_in_ready",  bus.in_ready, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_sum",   bus.out_sum, 0);
        check("midrst_out_ovf",   bus.out_ovf, 0);
        check("midrst_out_beats", bus.out_beats, 0);
        tick();
        rst = 1'b0;
        #1;
        check("midrst_release_ready", bus.in_ready, 1);
        send_beat(4, 3, 2, 1, 1'b0);
        send_beat(4, 3, 2, 1, 1'b1);
        wait_result(lat);
        finish_result("after_rst", 20, 0, 20, 0, 2, 0);

        // Randomized packets with input gaps and output stalls.
        for (int p = 0; p < 200; p++) begin
            len = (p % 20 == 0) ? int'($urandom_range(256, 300)) : int'($urandom_range(1, 300));
            acc = 0;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.in_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) tick();
                end
                a  = int'($urandom_range(0, 15));
                b  = int'($urandom_range(0, 15));
                c  = int'($urandom_range(0, 15));
                ci = int'($urandom_range(0, 1));
                acc += a + b + c + ci;
                send_beat(a, b, c, ci, i == len - 1);
            end
            bmax = (len > 255) ? 255 : len;
            wait_result(lat);
            check($sformatf("rnd%0d_latency", p), lat, 2);
            finish_result($sformatf("rnd%0d", p), acc % 65536, (acc > 65535) ? 1 : 0,
                          acc % 256, (acc > 255) ? 1 : 0, bmax, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/triple_operand_accumulator.md
# triple_operand_accumulator

Streaming accumulator directly downstream of the 3-operand 4-bit carry-lookahead adder. Each accepted beat carries three 4-bit operands plus a carry-in. The block reduces each beat to a 6-bit triple sum, {cout_2, cout_1, sum[3:0]}, and folds it into a wide running accumulator. On the packet's last beat it presents the total, a sticky overflow flag and the beat count on a valid/ready output port. It is the reduction back-end for multi-operand partial-product columns in the multiplier datapath.

## Interface
- ACC_W, 16, accumulator and result width; legal range 8..32.
- CNT_W, 8, beat-counter width; the counter saturates at 2^CNT_W-1.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in1, in2, in3  in  4 each  operands, unsigned.
- cin  in  1  per-beat carry-in, weight 1.
- in_last  in  1  marks the final beat of a packet.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  packet total, modulo 2^ACC_W.
- out_ovf  out  1  packet total exceeded 2^ACC_W-1.
- out_beats  out  CNT_W  number of beats in the packet, saturating.

## Operation
- Triple sum per beat: t = in1+in2+in3+cin. The range is 0..46, held in 6 bits. Bit 4 carries weight 16 and bit 5 carries weight 32, which matches the adder's cout_1 and cout_2. t is zero-extended to ACC_W.
- Stage 1 registers: s1_val, s1_t[5:0], s1_last. They load on each input handshake (in_valid & in_ready). s1_val clears on any cycle with no handshake.
- Stage 2 holds acc[ACC_W-1:0], ovf and cnt. On s1_val:
  - acc <= acc + s1_t.
  - ovf <= ovf | carry-out of bit ACC_W-1.
  - cnt <= cnt+1, saturating.
- FSM states:
  - ACC: in_ready=1. A handshake with in_last=1 moves to FLUSH.
  - FLUSH: in_ready=0. The final stage-1 beat folds into acc, ovf and cnt. Next state is DONE unconditionally.
  - DONE: in_ready=0, out_valid=1. out_sum=acc, out_ovf=ovf, out_beats=cnt. On out_ready=1: acc, ovf and cnt clear to 0 and the state returns to ACC.
- Outputs hold stable while out_valid=1 and out_ready=0.
- in_valid is ignored outside ACC; no beat is lost or duplicated.
- Single-beat packet (in_last on the first beat) is legal; out_beats=1.
- A beat of all zeros still counts as a beat.
- Reset (asynchronous, any state, including mid-packet):
  - State returns to ACC.
  - acc, ovf, cnt, s1_val, s1_t and s1_last clear to 0.
  - out_valid=0, out_sum=0, out_ovf=0, out_beats=0.
  - in_ready is forced to 0 while rst=1 and reads 1 from the first cycle after rst deasserts.
  - A partial packet in flight is discarded.

## Timing
- Throughput is 1 beat/cycle in ACC.
- A beat handshaken at edge k is in stage 1 after k and in acc after k+1.
- Last-beat handshake at edge k: FLUSH after k, DONE after k+1. out_valid=1 in the cycle following edge k+1, i.e. 2 cycles of latency.
- Result handshake at edge m: out_valid=0 and in_ready=1 after m. The next packet's first beat can be accepted at edge m+1.
- Per-packet overhead beyond the beats is 2 cycles plus output stall cycles.
- There is no combinational path from out_ready to in_ready or to any data output.

## Test plan
1. Reset, then 4 beats of in1=in2=in3=15, cin=1, with in_last on beat 4; out_ready=1 throughout.
   Required: out_sum=184, out_ovf=0, out_beats=4. out_valid rises exactly 2 cycles after the beat-4 handshake.
2. Single beat in1=3, in2=5, in3=9, cin=0, in_last=1.
   Required: out_sum=17, out_beats=1. The result must exercise bit 4 (the cout_1 path).
3. ACC_W=8: 6 beats of t=46 (all 15s, cin=1).
   Required: out_sum=20, out_ovf=1, out_beats=6. A following packet of a single beat with t=1 gives out_sum=1, out_ovf=0.
4. Hold out_ready=0 for 5 cycles in DONE while toggling in_valid, then raise it.
   Required: outputs stable throughout, in_ready=0, no beats absorbed. The next packet's totals are unaffected.
5. Assert rst for 1 cycle after 3 of 5 beats (each t=10).
   Required: all outputs read 0 immediately. A new 2-beat packet with t=10 each returns out_sum=20, out_beats=2.
6. Random in_valid gaps over 200 packets with lengths 1..300 and CNT_W=8.
   Required: out_sum and out_ovf match a reference model. out_beats saturates at 255 for packets longer than 255 beats.
